led_decode_sched: RTL and testbench

LED_DECODE_SCHED -- requirements
Module: led_decode_sched

---
 rtl/led_decode_sched.sv | 151 +++++++++++++++
 tb/tb_led_decode_sched.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/led_decode_sched.sv
// Round-robin scheduler giving four requesters timed, non-preemptive ownership of a 3-to-8 LED decoder.
// Optional macro LEDSCHED_BLANK_EN inserts a one-cycle blank (decoder off) after every grant.
module led_decode_sched #(
    parameter int DWELL = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  req,
    input  logic [11:0] idx,
    output logic [3:0]  grant,
    output logic        done,
    output logic [2:0]  switch,
    output logic [2:0]  enable,
    output logic [7:0]  led
);

`ifdef LEDSCHED_BLANK_EN
    typedef enum logic [1:0] {IDLE = 2'd0, HOLD = 2'd1, BLANK = 2'd2} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, HOLD = 2'd1} state_t;
`endif

    localparam logic [7:0] DWELL_M1 = 8'(DWELL - 1);

    state_t      state_r, state_s;
    logic [1:0]  ptr_r, ptr_s, off_s, win_s;
    logic [7:0]  cnt_r, cnt_s;
    logic [3:0]  grant_r, grant_s, rot_s;
    logic [2:0]  switch_r, switch_s, enable_r, enable_s, win_idx_s;
    logic        done_r, done_s, any_s, arb_s;
    logic [7:0]  led_r, led_s;
`ifdef LEDSCHED_BLANK_EN
    logic        to_blank_s;
`endif

    // Round-robin pick: rotate requests so ptr sits at bit 0, then take the lowest set bit.
    always_comb begin
        rot_s = 4'({req, req} >> ptr_r);
        any_s = |req;
        casez (rot_s)
            4'b???1: off_s = 2'd0;
            4'b??10: off_s = 2'd1;
            4'b?100: off_s = 2'd2;
            4'b1000: off_s = 2'd3;
            default: off_s = 2'd0;
        endcase
        win_s = ptr_r + off_s;
        case (win_s)
            2'd0:    win_idx_s = idx[2:0];
            2'd1:    win_idx_s = idx[5:3];
            2'd2:    win_idx_s = idx[8:6];
            2'd3:    win_idx_s = idx[11:9];
            default: win_idx_s = idx[2:0];
        endcase
    end

    // Next-state and next-output logic for the grant FSM.
    always_comb begin
        state_s  = state_r;
        ptr_s    = ptr_r;
        cnt_s    = cnt_r;
        grant_s  = grant_r;
        switch_s = switch_r;
        enable_s = enable_r;
        arb_s    = 1'b0;
`ifdef LEDSCHED_BLANK_EN
        to_blank_s = 1'b0;
`endif
        case (state_r)
            IDLE:    arb_s = 1'b1;
`ifdef LEDSCHED_BLANK_EN
            HOLD:    to_blank_s = (cnt_r == 8'd0);
            BLANK:   arb_s = 1'b1;
`else
            HOLD:    arb_s = (cnt_r == 8'd0);
`endif
            default: arb_s = 1'b1;
        endcase

        if (arb_s && any_s) begin
            state_s  = HOLD;
            grant_s  = 4'b0001 << win_s;
            switch_s = win_idx_s;
            enable_s = 3'b100;
            cnt_s    = DWELL_M1;
            ptr_s    = win_s + 2'd1;
        end else if (arb_s) begin
            state_s  = IDLE;
            grant_s  = 4'b0000;
            enable_s = 3'b000;
            cnt_s    = 8'd0;
`ifdef LEDSCHED_BLANK_EN
        end else if (to_blank_s) begin
            state_s  = BLANK;
            grant_s  = 4'b0000;
            enable_s = 3'b000;
`endif
        end else begin
            // Only HOLD with time remaining reaches here; switch holds while idle.
            cnt_s = cnt_r - 8'd1;
        end

        done_s = (state_s == HOLD) && (cnt_s == 8'd0);
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r  <= IDLE;
            ptr_r    <= 2'd0;
            cnt_r    <= 8'd0;
            grant_r  <= 4'b0000;
            switch_r <= 3'b000;
            enable_r <= 3'b000;
            done_r   <= 1'b0;
        end else begin
            state_r  <= state_s;
            ptr_r    <= ptr_s;
            cnt_r    <= cnt_s;
            grant_r  <= grant_s;
            switch_r <= switch_s;
            enable_r <= enable_s;
            done_r   <= done_s;
        end
    end

    // Active-low one-hot LED pattern for the decoder state of the previous cycle.
    always_comb begin
        if (enable_r == 3'b100) begin
            led_s = ~(8'd1 << switch_r);
        end else begin
            led_s = 8'hFF;
        end
    end

    // LED drive register, one cycle behind switch/enable.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            led_r <= 8'hFF;
        end else begin
            led_r <= led_s;
        end
    end

    assign grant  = grant_r;
    assign done   = done_r;
    assign switch = switch_r;
    assign enable = enable_r;
    assign led    = led_r;

endmodule

// File: tb/tb_led_decode_sched.sv
// Self-checking bench for led_decode_sched: three instances (DWELL 4, 2, 1) against a remaining-cycles model.
// Define LEDSCHED_BLANK_EN for both RTL and bench to exercise the blank-cycle build.
module tb_led_decode_sched;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  req = 4'b0000;
    logic [11:0] idx = 12'd0;

    logic [3:0] grant_a [3];
    logic       done_a  [3];
    logic [2:0] sw_a    [3];
    logic [2:0] en_a    [3];
    logic [7:0] led_a   [3];

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    genvar g;
    generate
        for (g = 0; g < 3; g++) begin : g_dut
            led_decode_sched #(.DWELL(g == 0 ? 4 : (g == 1 ? 2 : 1))) u_dut (
                .clk(clk), .rst(rst), .req(req), .idx(idx),
                .grant(grant_a[g]), .done(done_a[g]), .switch(sw_a[g]),
                .enable(en_a[g]), .led(led_a[g])
            );
        end
    endgenerate

    // Model: who owns the decoder and how many cycles of ownership are left.
    typedef struct packed {
        logic       busy;
        logic [1:0] owner;
        logic [8:0] left;
        logic [1:0] ptr;
        logic [2:0] sw;
        logic [7:0] led;
    } model_t;

    model_t m [3];

    function automatic int dw_of(int k);
        return (k == 0) ? 4 : ((k == 1) ? 2 : 1);
    endfunction

    function automatic model_t model_reset();
        model_t s;
        s = '0;
        s.led = 8'hFF;
        return s;
    endfunction

    function automatic model_t model_next(model_t s, int dw, logic [3:0] r, logic [11:0] ix);
        model_t n;
        bit arb;
        int c;
        n = s;
        arb = 1'b0;
        n.led = s.busy ? ~(8'd1 << s.sw) : 8'hFF;
        if (s.busy && s.left > 9'd1) begin
            n.left = s.left - 9'd1;
        end else if (s.busy) begin
`ifdef LEDSCHED_BLANK_EN
            n.busy = 1'b0;
`else
            arb = 1'b1;
`endif
        end else begin
            arb = 1'b1;
        end
        if (arb) begin
            n.busy = 1'b0;
            for (int j = 0; j < 4; j++) begin
                c = (int'(s.ptr) + j) % 4;
                if (!n.busy && r[c]) begin
                    n.busy  = 1'b1;
                    n.owner = 2'(c);
                    n.left  = 9'(dw);
                    n.sw    = ix[3*c +: 3];
                    n.ptr   = 2'((c + 1) % 4);
                end
            end
        end
        return n;
    endfunction

    always @(posedge clk or posedge rst) begin
        for (int k = 0; k < 3; k++) begin
            if (rst) m[k] <= model_reset();
            else     m[k] <= model_next(m[k], dw_of(k), req, idx);
        end
    end

    function automatic logic [18:0] exp_vec(int k);
        model_t s;
        s = m[k];
        return {s.busy ? 4'(4'b0001 << s.owner) : 4'b0000,
                s.busy && (s.left == 9'd1), s.sw,
                s.busy ? 3'b100 : 3'b000, s.led};
    endfunction

    function automatic logic [18:0] obs_vec(int k);
        return {grant_a[k], done_a[k], sw_a[k], en_a[k], led_a[k]};
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        req = 4'b0000;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (obs_vec(k) !== 19'h000FF) begin
                failures++;
                $display("FAIL reset_state dut%0d got %h exp %h", k, obs_vec(k), 19'h000FF);
            end
        end
    endtask

    task automatic test_single_grant();
        int gcnt = 0, dcnt = 0, lcnt = 0;
        do_reset();
        req = 4'b0010;
        idx = 12'($urandom);
        idx[5:3] = 3'd5;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (obs_vec(k) !== exp_vec(k)) begin
                    failures++;
                    $display("FAIL single_model dut%0d cyc %0d got %h exp %h", k, c, obs_vec(k), exp_vec(k));
                end
            end
            if (grant_a[0] == 4'b0010 && sw_a[0] == 3'd5) gcnt++;
            if (done_a[0] && c == 3) dcnt++;
            else if (done_a[0]) dcnt += 10;
            if (led_a[0] == 8'hDF && c >= 1) lcnt++;
            if (c == 0) req = 4'b0000;
        end
        checks++;
        if (gcnt != 4 || dcnt != 1 || lcnt != 4) begin
            failures++;
            $display("FAIL single_counts got grant=%0d done=%0d led=%0d exp 4 1 4", gcnt, dcnt, lcnt);
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] seq[$];
        logic [3:0] pg = 4'b0000;
        logic       pd = 1'b0;
        int drops = 0;
`ifdef LEDSCHED_BLANK_EN
        int win = 14, exp_drops = 4;
`else
        int win = 10, exp_drops = 0;
`endif
        do_reset();
        req = 4'b1111;
        for (int c = 0; c < win; c++) begin
            @(negedge clk);
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (obs_vec(k) !== exp_vec(k)) begin
                    failures++;
                    $display("FAIL b2b_model dut%0d cyc %0d got %h exp %h", k, c, obs_vec(k), exp_vec(k));
                end
            end
            if (grant_a[1] != 4'b0000 && (pg == 4'b0000 || pd)) seq.push_back(grant_a[1]);
            if (en_a[1] == 3'b000) drops++;
            pg = grant_a[1];
            pd = done_a[1];
            idx = 12'($urandom);
        end
        checks++;
        if (seq.size() != 5 || drops != exp_drops) begin
            failures++;
            $display("FAIL b2b_shape got grants=%0d drops=%0d exp 5 %0d", seq.size(), drops, exp_drops);
        end
        for (int i = 0; i < seq.size() && i < 5; i++) begin
            checks++;
            if (seq[i] !== 4'(4'b0001 << (i % 4))) begin
                failures++;
                $display("FAIL b2b_order grant %0d got %b exp %b", i, seq[i], 4'(4'b0001 << (i % 4)));
            end
        end
        req = 4'b0000;
    endtask

    task automatic test_non_preemptive();
        do_reset();
        req = 4'b0100;
        idx = 12'($urandom);
        idx[8:6] = 3'd3;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (obs_vec(k) !== exp_vec(k)) begin
                    failures++;
                    $display("FAIL nonpre_model dut%0d cyc %0d got %h exp %h", k, c, obs_vec(k), exp_vec(k));
                end
            end
            if (c < 4) begin
                checks++;
                if (grant_a[0] !== 4'b0100 || sw_a[0] !== 3'd3) begin
                    failures++;
                    $display("FAIL nonpre_hold cyc %0d got grant=%b sw=%0d exp 0100 3", c, grant_a[0], sw_a[0]);
                end
            end
            if (c == 0) begin
                req = 4'b0000;
                idx[8:6] = 3'd6;
            end
        end
    endtask

    task automatic test_reset_mid_grant();
        int dcnt = 0;
        do_reset();
        req = 4'b1000;
        idx = 12'($urandom);
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            checks++;
            if (grant_a[0] !== 4'b1000) begin
                failures++;
                $display("FAIL midrst_grant cyc %0d got %b exp 1000", c, grant_a[0]);
            end
            if (done_a[0]) dcnt++;
        end
        rst = 1'b1;
        #1;
        checks++;
        if (grant_a[0] !== 4'b0000 || led_a[0] !== 8'hFF || done_a[0] !== 1'b0 || en_a[0] !== 3'b000) begin
            failures++;
            $display("FAIL midrst_abort got grant=%b led=%h done=%b en=%b exp 0000 ff 0 000",
                     grant_a[0], led_a[0], done_a[0], en_a[0]);
        end
        req = 4'b1001;
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (obs_vec(k) !== exp_vec(k)) begin
                    failures++;
                    $display("FAIL midrst_model dut%0d cyc %0d got %h exp %h", k, c, obs_vec(k), exp_vec(k));
                end
            end
            if (done_a[0]) dcnt++;
            if (c == 0) begin
                checks++;
                if (grant_a[0] !== 4'b0001) begin
                    failures++;
                    $display("FAIL midrst_restart got %b exp 0001", grant_a[0]);
                end
            end
        end
        checks++;
        if (dcnt != 0) begin
            failures++;
            $display("FAIL midrst_done got %0d done cycles exp 0", dcnt);
        end
        req = 4'b0000;
    endtask

    task automatic test_dwell_one();
        logic [3:0] eg;
        logic       ed;
        do_reset();
        req = 4'b0101;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (obs_vec(k) !== exp_vec(k)) begin
                    failures++;
                    $display("FAIL dwell1_model dut%0d cyc %0d got %h exp %h", k, c, obs_vec(k), exp_vec(k));
                end
            end
`ifdef LEDSCHED_BLANK_EN
            eg = (c % 2 == 1) ? 4'b0000 : ((c % 4 == 0) ? 4'b0001 : 4'b0100);
`else
            eg = (c % 2 == 1) ? 4'b0100 : 4'b0001;
`endif
            ed = (eg != 4'b0000);
            checks++;
            if (grant_a[2] !== eg || done_a[2] !== ed) begin
                failures++;
                $display("FAIL dwell1_seq cyc %0d got grant=%b done=%b exp %b %b", c, grant_a[2], done_a[2], eg, ed);
            end
        end
        req = 4'b0000;
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (obs_vec(k) !== exp_vec(k)) begin
                    failures++;
                    $display("FAIL random_model dut%0d cyc %0d got %h exp %h", k, c, obs_vec(k), exp_vec(k));
                end
            end
            req = ($urandom_range(0, 3) == 0) ? 4'b0000 : 4'($urandom);
            idx = 12'($urandom);
            rst = ($urandom_range(0, 59) == 0);
        end
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_grant();
        test_back_to_back();
        test_non_preemptive();
        test_reset_mid_grant();
        test_dwell_one();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
